// File: rtl/servo_pkg.sv
// Shared defaults and the update-FSM state type for the servo command conditioner.
package servo_pkg;

  localparam int DFLT_CLK_HZ          = 50_000_000;
  localparam int DFLT_CNT_WIDTH       = 20;
  localparam int DFLT_FRAME_TICKS     = DFLT_CLK_HZ / 50;      // 20 ms
  localparam int DFLT_PULSE_MIN_TICKS = DFLT_CLK_HZ / 1_000;   // 1.0 ms
  localparam int DFLT_PULSE_MAX_TICKS = DFLT_CLK_HZ / 500;     // 2.0 ms
  localparam int DFLT_DEBOUNCE_TICKS  = DFLT_CLK_HZ / 1_000;   // 1 ms
  localparam int DFLT_SLEW_STEP       = DFLT_CLK_HZ / 10_000;

  typedef enum logic [1:0] {
    SETTLED   = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2
  } servo_state_e;

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchronizer followed by a persistence debouncer for one asynchronous board input.
module sync_debounce
  import servo_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = DFLT_DEBOUNCE_TICKS
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic async_i,
  output logic level_o
);

  localparam int CW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;

  logic          sync_p0;
  logic          sync_p1;
  logic [CW-1:0] cnt;

  // stage p0/p1: metastability filter
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= async_i;
      sync_p1 <= sync_p0;
    end
  end

  // stage p2: a new level is accepted only after DEBOUNCE_TICKS consecutive differing samples
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt     <= '0;
      level_o <= 1'b0;
    end else if (sync_p1 != level_o) begin
      if (cnt == CW'(DEBOUNCE_TICKS - 1)) begin
        level_o <= sync_p1;
        cnt     <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/servo_cmd_conditioner.sv
// Servo command front end: synchronize/debounce the command input, then move the PWM width
// toward the selected target once per frame. `define SERVO_CMD_SLEW_EN limits each move to SLEW_STEP.
module servo_cmd_conditioner
  import servo_pkg::*;
#(
  parameter int CNT_WIDTH       = DFLT_CNT_WIDTH,
  parameter int FRAME_TICKS     = DFLT_FRAME_TICKS,
  parameter int PULSE_MIN_TICKS = DFLT_PULSE_MIN_TICKS,
  parameter int PULSE_MAX_TICKS = DFLT_PULSE_MAX_TICKS,
  parameter int DEBOUNCE_TICKS  = DFLT_DEBOUNCE_TICKS,
  parameter int SLEW_STEP       = DFLT_SLEW_STEP
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 comp_async_i,
  output logic [CNT_WIDTH-1:0] width_o,
  output logic                 width_valid_o,
  output logic                 frame_tick_o,
  output logic                 settled_o
);

  if ((PULSE_MIN_TICKS > PULSE_MAX_TICKS) ||
      (longint'(PULSE_MAX_TICKS) >= (longint'(1) << CNT_WIDTH)) ||
      (longint'(FRAME_TICKS) > (longint'(1) << CNT_WIDTH)) ||
      (SLEW_STEP < 1) || (DEBOUNCE_TICKS < 1)) begin : g_bad_cfg
    $error("servo_cmd_conditioner: inconsistent parameter set");
  end

`ifdef SERVO_CMD_SLEW_EN
  // One spare bit for the sum and one for sign keeps the ramp free of wrap-around.
  typedef logic signed [CNT_WIDTH+1:0] acc_t;

  function automatic acc_t widen(input logic [CNT_WIDTH-1:0] v);
    return $signed({2'b00, v});
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_up(input logic [CNT_WIDTH-1:0] w,
                                                  input logic [CNT_WIDTH-1:0] t);
    acc_t sum;
    sum = widen(w) + acc_t'(SLEW_STEP);
    return (sum > widen(t)) ? t : sum[CNT_WIDTH-1:0];
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_down(input logic [CNT_WIDTH-1:0] w,
                                                    input logic [CNT_WIDTH-1:0] t);
    acc_t diff;
    diff = widen(w) - acc_t'(SLEW_STEP);
    return (diff < widen(t)) ? t : diff[CNT_WIDTH-1:0];
  endfunction
`endif

  logic                 level_p2;
  logic [CNT_WIDTH-1:0] target;
  logic [CNT_WIDTH-1:0] frame_cnt;
  logic [CNT_WIDTH-1:0] width_nxt;
  logic                 vld_p3;
  servo_state_e         state, state_nxt;

  sync_debounce #(
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
  ) u_sync_debounce (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .async_i(comp_async_i),
    .level_o(level_p2)
  );

  assign target       = level_p2 ? CNT_WIDTH'(PULSE_MAX_TICKS) : CNT_WIDTH'(PULSE_MIN_TICKS);
  assign frame_tick_o = (frame_cnt == CNT_WIDTH'(FRAME_TICKS - 1));
  assign settled_o    = (state == SETTLED);

  always_ff @(posedge clk_i) begin
    if (reset_i)           frame_cnt <= '0;
    else if (frame_tick_o) frame_cnt <= '0;
    else                   frame_cnt <= frame_cnt + 1'b1;
  end

  // A move also requires the live compare to agree, so a state one cycle stale after a
  // target change can never push width_o past the new target.
  always_comb begin
    state_nxt = SETTLED;
    width_nxt = width_o;
    vld_p3    = 1'b0;
    if (width_o < target)      state_nxt = RAMP_UP;
    else if (width_o > target) state_nxt = RAMP_DOWN;
    if (frame_tick_o) begin
      if ((state == RAMP_UP) && (width_o < target)) begin
        vld_p3 = 1'b1;
`ifdef SERVO_CMD_SLEW_EN
        width_nxt = sat_up(width_o, target);
`else
        width_nxt = target;
`endif
      end else if ((state == RAMP_DOWN) && (width_o > target)) begin
        vld_p3 = 1'b1;
`ifdef SERVO_CMD_SLEW_EN
        width_nxt = sat_down(width_o, target);
`else
        width_nxt = target;
`endif
      end
    end
  end

  // stage p3: registered width and its update strobe
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state         <= SETTLED;
      width_o       <= CNT_WIDTH'(PULSE_MIN_TICKS);
      width_valid_o <= 1'b0;
    end else begin
      state         <= state_nxt;
      width_o       <= width_nxt;
      width_valid_o <= vld_p3;
    end
  end

endmodule

// File: tb/tb_servo_cmd_conditioner.sv
// Directed scoreboard bench: two channels (slew 4 and slew 6) with per-channel expected-width queues.
module tb_servo_cmd_conditioner;

  localparam int CW  = 8;
  localparam int FT  = 100;
  localparam int DT  = 8;
  localparam int PMN = 10;
  localparam int PMX = 30;

  logic          clk = 1'b0;
  logic          rst_a, rst_b, comp_a, comp_b;
  logic [CW-1:0] width_a, width_b;
  logic          vld_a, vld_b, tick_a, tick_b, set_a, set_b;

  int            n_cmp = 0;
  int            n_fail = 0;
  int unsigned   expq_a[$];
  int unsigned   expq_b[$];
  int unsigned   e_a, e_b;
  logic [CW-1:0] prev_wa, prev_wb;
  logic          prev_ta, prev_tb;
  int            tick_cnt;
  logic          all_set;

  always #5 clk = ~clk;

  servo_cmd_conditioner #(
    .CNT_WIDTH(CW), .FRAME_TICKS(FT), .PULSE_MIN_TICKS(PMN), .PULSE_MAX_TICKS(PMX),
    .DEBOUNCE_TICKS(DT), .SLEW_STEP(4)
  ) u_dut_a (
    .clk_i(clk), .reset_i(rst_a), .comp_async_i(comp_a), .width_o(width_a),
    .width_valid_o(vld_a), .frame_tick_o(tick_a), .settled_o(set_a)
  );

  servo_cmd_conditioner #(
    .CNT_WIDTH(CW), .FRAME_TICKS(FT), .PULSE_MIN_TICKS(PMN), .PULSE_MAX_TICKS(PMX),
    .DEBOUNCE_TICKS(DT), .SLEW_STEP(6)
  ) u_dut_b (
    .clk_i(clk), .reset_i(rst_b), .comp_async_i(comp_b), .width_o(width_b),
    .width_valid_o(vld_b), .frame_tick_o(tick_b), .settled_o(set_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drain_a(input string tag);
    int i;
    i = 0;
    while (expq_a.size() != 0 && i < 800) begin
      @(negedge clk);
      i++;
    end
    chk(tag, 32'(expq_a.size()), 32'd0);
  endtask

  task automatic drain_b(input string tag);
    int i;
    i = 0;
    while (expq_b.size() != 0 && i < 800) begin
      @(negedge clk);
      i++;
    end
    chk(tag, 32'(expq_b.size()), 32'd0);
  endtask

  // Output monitors: every strobe pops the next expected width and must follow a frame tick;
  // any width change outside reset must carry a strobe.
  always begin
    @(posedge clk);
    #1;
    if (vld_a) begin
      e_a = (expq_a.size() != 0) ? expq_a.pop_front() : 32'hFFFF_FFFF;
      chk("A_width", 32'(width_a), e_a);
      chk("A_vld_after_tick", 32'(prev_ta), 32'd1);
    end else if (!rst_a && (width_a !== prev_wa)) begin
      chk("A_change_without_vld", 32'(width_a), 32'(prev_wa));
    end
    prev_wa = width_a;
    prev_ta = tick_a;
  end

  always begin
    @(posedge clk);
    #1;
    if (vld_b) begin
      e_b = (expq_b.size() != 0) ? expq_b.pop_front() : 32'hFFFF_FFFF;
      chk("B_width", 32'(width_b), e_b);
      chk("B_vld_after_tick", 32'(prev_tb), 32'd1);
    end else if (!rst_b && (width_b !== prev_wb)) begin
      chk("B_change_without_vld", 32'(width_b), 32'(prev_wb));
    end
    prev_wb = width_b;
    prev_tb = tick_b;
  end

  initial begin
    #500_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; comp_a = 1'b0; comp_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_width_a", 32'(width_a), PMN);
    chk("rst_settled_a", 32'(set_a), 32'd1);
    chk("rst_vld_a", 32'(vld_a), 32'd0);
    chk("rst_tick_a", 32'(tick_a), 32'd0);
    chk("rst_width_b", 32'(width_b), PMN);
    rst_a = 1'b0; rst_b = 1'b0;

    // Frame tick: first on the 100th cycle after release, then every 100.
    tick_cnt = 0;
    for (int k = 1; k <= 199; k++) begin
      @(negedge clk);
      if (k == 99)       chk("tick_first", 32'(tick_a), 32'd1);
      else if (k == 199) chk("tick_second", 32'(tick_a), 32'd1);
      else if (tick_a)   tick_cnt++;
    end
    chk("tick_quiet_between", 32'(tick_cnt), 32'd0);

    // Glitches of 5 and DEBOUNCE_TICKS-1 cycles must be ignored.
    for (int g = 0; g < 2; g++) begin
      all_set = 1'b1;
      comp_a = 1'b1;
      repeat ((g == 0) ? 5 : DT - 1) begin
        @(negedge clk);
        all_set &= set_a;
      end
      comp_a = 1'b0;
      repeat (30) begin
        @(negedge clk);
        all_set &= set_a;
      end
      chk("glitch_settled", 32'(all_set), 32'd1);
      chk("glitch_width", 32'(width_a), PMN);
    end

    // Ramp up: settled_o falls exactly 11 cycles after the input edge.
`ifdef SERVO_CMD_SLEW_EN
    expq_a = {14, 18, 22, 26, 30};
`else
    expq_a = {30};
`endif
    comp_a = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k == 10) chk("settle_hold_10", 32'(set_a), 32'd1);
      if (k == 11) chk("settle_fall_11", 32'(set_a), 32'd0);
    end
    drain_a("rampup_drain");
    repeat (2) @(negedge clk);
    chk("rampup_settled", 32'(set_a), 32'd1);
    repeat (250) @(negedge clk);
    chk("rampup_hold_width", 32'(width_a), PMX);

    // Ramp down to the minimum.
`ifdef SERVO_CMD_SLEW_EN
    expq_a = {26, 22, 18, 14, 10};
`else
    expq_a = {10};
`endif
    comp_a = 1'b0;
    drain_a("rampdown_drain");
    repeat (2) @(negedge clk);
    chk("rampdown_settled", 32'(set_a), 32'd1);
    chk("rampdown_width", 32'(width_a), PMN);

`ifdef SERVO_CMD_SLEW_EN
    // Reversal mid-ramp at 22.
    expq_a = {14, 18, 22};
    comp_a = 1'b1;
    drain_a("rev_up_drain");
    chk("rev_at_22", 32'(width_a), 32'd22);
    expq_a = {18, 14, 10};
    comp_a = 1'b0;
    drain_a("rev_down_drain");
    repeat (2) @(negedge clk);
    chk("rev_settled", 32'(set_a), 32'd1);
    chk("rev_width", 32'(width_a), PMN);
`endif

    // Channel B (step 6): last step clamps at the target.
`ifdef SERVO_CMD_SLEW_EN
    expq_b = {16, 22, 28, 30};
`else
    expq_b = {30};
`endif
    comp_b = 1'b1;
    drain_b("clamp_up_drain");
    repeat (2) @(negedge clk);
    chk("clamp_up_settled", 32'(set_b), 32'd1);
    chk("clamp_up_width", 32'(width_b), PMX);

`ifdef SERVO_CMD_SLEW_EN
    expq_b = {24, 18, 12, 10};
`else
    expq_b = {10};
`endif
    comp_b = 1'b0;
    drain_b("clamp_down_drain");
    repeat (2) @(negedge clk);
    chk("clamp_down_width", 32'(width_b), PMN);

    // Reset mid-ramp discards all progress.
    comp_b = 1'b1;
`ifdef SERVO_CMD_SLEW_EN
    expq_b = {16, 22};
    drain_b("midramp_drain");
    chk("midramp_at_22", 32'(width_b), 32'd22);
`else
    tick_cnt = 0;
    while (set_b && tick_cnt < 40) begin
      @(negedge clk);
      tick_cnt++;
    end
    chk("midramp_ramping", 32'(set_b), 32'd0);
`endif
    rst_b = 1'b1;
    comp_b = 1'b0;
    @(negedge clk);
    chk("midramp_rst_width", 32'(width_b), PMN);
    chk("midramp_rst_settled", 32'(set_b), 32'd1);
    chk("midramp_rst_vld", 32'(vld_b), 32'd0);
    rst_b = 1'b0;
    repeat (250) @(negedge clk);
    chk("midramp_after_width", 32'(width_b), PMN);
    chk("midramp_after_settled", 32'(set_b), 32'd1);
    chk("queue_a_empty_end", 32'(expq_a.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
